register_file_scoreboard: RTL and testbench

//  Parametrised 2-read/1-write register file for the pipelined RISC-V core; successor to the fixed 32x32 single-cycle file.

---
 rtl/register_file_scoreboard_if.sv | 40 ++++
 rtl/register_file_scoreboard.sv | 129 ++++++++++++
 tb/tb_register_file_scoreboard.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/register_file_scoreboard_if.sv
// Decode/writeback bundle for the scoreboarded register file.
// Latency: none, wires only.
// Backpressure: none; decode watches busy_1/busy_2 to stall on RAW hazards.
interface register_file_scoreboard_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  // writeback side
  logic                  reg_write;
  logic [ADDR_WIDTH-1:0] write_register;
  logic [DATA_WIDTH-1:0] write_data;
  // decode side: operand reads
  logic [ADDR_WIDTH-1:0] read_register_1;
  logic [ADDR_WIDTH-1:0] read_register_2;
  // decode side: destination reservation at issue
  logic                  reserve;
  logic [ADDR_WIDTH-1:0] reserve_register;
  logic                  flush;
  // results back to decode
  logic [DATA_WIDTH-1:0] read_data_1;
  logic [DATA_WIDTH-1:0] read_data_2;
  logic                  busy_1;
  logic                  busy_2;

  // pipeline side: drives indices/data, consumes read results
  modport master (
    output reg_write, write_register, write_data,
    output read_register_1, read_register_2,
    output reserve, reserve_register, flush,
    input  read_data_1, read_data_2, busy_1, busy_2
  );

  // register file side
  modport slave (
    input  reg_write, write_register, write_data,
    input  read_register_1, read_register_2,
    input  reserve, reserve_register, flush,
    output read_data_1, read_data_2, busy_1, busy_2
  );
endinterface

// File: rtl/register_file_scoreboard.sv
// 2-read/1-write register file with write-to-read bypass and per-entry pending-write scoreboard.
// Latency: reads combinational (READ_LATENCY=0) or one edge (READ_LATENCY=1); writes/reserves land at the edge.
// Backpressure: none; busy outputs tell decode to stall until the producer writes back.
module register_file_scoreboard #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int ZERO_REG     = 1,
  parameter int BYPASS_EN    = 1,
  parameter int READ_LATENCY = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  register_file_scoreboard_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

  data_t            entry_q [DEPTH];
  logic [DEPTH-1:0] pending_q;
  logic [DEPTH-1:0] pending_d;

  logic  write_ok;
  logic  reserve_ok;
  addr_t rd_addr    [2];
  logic  bypass_hit [2];
  data_t rd_data    [2];
  logic  rd_busy    [2];

  // x0 is hardwired only when ZERO_REG is set; otherwise it is an ordinary entry
  function automatic logic is_zero_reg(input addr_t a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // writes and reservations to a hardwired x0 are dropped before touching any state
  assign write_ok   = bus.reg_write && !is_zero_reg(bus.write_register);
  assign reserve_ok = bus.reserve   && !is_zero_reg(bus.reserve_register);

  assign rd_addr[0] = bus.read_register_1;
  assign rd_addr[1] = bus.read_register_2;

  // register storage: writeback updates one entry per edge, flush never touches data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else if (write_ok) begin
      entry_q[bus.write_register] <= bus.write_data;
    end
  end

  // next pending set: flush wins outright; otherwise a new reservation overrides the
  // clear from a writeback to the same index, since the reserving instruction is the
  // younger producer
  always_comb begin
    pending_d = pending_q;
    if (bus.flush) begin
      pending_d = '0;
    end else begin
      if (write_ok) begin
        pending_d[bus.write_register] = 1'b0;
      end
      if (reserve_ok) begin
        pending_d[bus.reserve_register] = 1'b1;
      end
    end
  end

  // scoreboard state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // per-port read value: bypass forwards the in-flight writeback and hides its pending bit,
  // a hardwired x0 always reads as idle zero
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      bypass_hit[p] = (BYPASS_EN != 0) && write_ok && (bus.write_register == rd_addr[p]);
      rd_data[p]    = bypass_hit[p] ? bus.write_data : entry_q[rd_addr[p]];
      rd_busy[p]    = pending_q[rd_addr[p]] && !bypass_hit[p];
      if (is_zero_reg(rd_addr[p])) begin
        rd_data[p] = '0;
        rd_busy[p] = 1'b0;
      end
    end
  end

  generate
    if (READ_LATENCY != 0) begin : g_read_reg
      data_t data_1_q;
      data_t data_2_q;
      logic  busy_1_q;
      logic  busy_2_q;

      // registered read stage: capture the combinational result, cleared by reset
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          data_1_q <= '0;
          data_2_q <= '0;
          busy_1_q <= 1'b0;
          busy_2_q <= 1'b0;
        end else begin
          data_1_q <= rd_data[0];
          data_2_q <= rd_data[1];
          busy_1_q <= rd_busy[0];
          busy_2_q <= rd_busy[1];
        end
      end

      assign bus.read_data_1 = data_1_q;
      assign bus.read_data_2 = data_2_q;
      assign bus.busy_1      = busy_1_q;
      assign bus.busy_2      = busy_2_q;
    end else begin : g_read_comb
      assign bus.read_data_1 = rd_data[0];
      assign bus.read_data_2 = rd_data[1];
      assign bus.busy_1      = rd_busy[0];
      assign bus.busy_2      = rd_busy[1];
    end
  endgenerate

endmodule

// File: tb/tb_register_file_scoreboard.sv
module tb_register_file_scoreboard;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N  = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // shared stimulus
  logic          reg_write, reserve, flush;
  logic [AW-1:0] write_register, read_register_1, read_register_2, reserve_register;
  logic [DW-1:0] write_data;

  register_file_scoreboard_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_a ();
  register_file_scoreboard_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_b ();
  register_file_scoreboard_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_c ();

  assign if_a.reg_write = reg_write;  assign if_b.reg_write = reg_write;  assign if_c.reg_write = reg_write;
  assign if_a.write_register = write_register;  assign if_b.write_register = write_register;  assign if_c.write_register = write_register;
  assign if_a.write_data = write_data;  assign if_b.write_data = write_data;  assign if_c.write_data = write_data;
  assign if_a.read_register_1 = read_register_1;  assign if_b.read_register_1 = read_register_1;  assign if_c.read_register_1 = read_register_1;
  assign if_a.read_register_2 = read_register_2;  assign if_b.read_register_2 = read_register_2;  assign if_c.read_register_2 = read_register_2;
  assign if_a.reserve = reserve;  assign if_b.reserve = reserve;  assign if_c.reserve = reserve;
  assign if_a.reserve_register = reserve_register;  assign if_b.reserve_register = reserve_register;  assign if_c.reserve_register = reserve_register;
  assign if_a.flush = flush;  assign if_b.flush = flush;  assign if_c.flush = flush;

  // a: bypass, combinational read; b: no bypass; c: bypass, registered read
  register_file_scoreboard #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1), .BYPASS_EN(1), .READ_LATENCY(0))
    dut_a (.clk(clk), .reset(reset), .bus(if_a.slave));
  register_file_scoreboard #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1), .BYPASS_EN(0), .READ_LATENCY(0))
    dut_b (.clk(clk), .reset(reset), .bus(if_b.slave));
  register_file_scoreboard #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1), .BYPASS_EN(1), .READ_LATENCY(1))
    dut_c (.clk(clk), .reset(reset), .bus(if_c.slave));

  int checks = 0;
  int errors = 0;

  // reference model: architectural register contents and the set of pending destinations
  logic [DW-1:0] m_mem  [N];
  bit            m_pend [N];
  // what the registered-read instance must show this cycle (captured at the last edge)
  logic [DW-1:0] lat_d1, lat_d2;
  logic          lat_b1, lat_b2;

  typedef struct {
    logic          wr;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] r1, r2;
    logic          rs;
    logic [AW-1:0] rsa;
    logic          fl;
    logic [DW-1:0] e_d1, e_d2;
    logic          e_b1, e_b2;
    logic [DW-1:0] e_nb_d2;
  } vec_t;

  vec_t vt [20];

  function automatic vec_t mk(logic wr, logic [AW-1:0] wa, logic [DW-1:0] wd, logic [AW-1:0] r1,
                              logic [AW-1:0] r2, logic rs, logic [AW-1:0] rsa, logic fl,
                              logic [DW-1:0] e_d1, logic [DW-1:0] e_d2, logic e_b1, logic e_b2,
                              logic [DW-1:0] e_nb_d2);
    vec_t v;
    v.wr = wr; v.wa = wa; v.wd = wd; v.r1 = r1; v.r2 = r2; v.rs = rs; v.rsa = rsa; v.fl = fl;
    v.e_d1 = e_d1; v.e_d2 = e_d2; v.e_b1 = e_b1; v.e_b2 = e_b2; v.e_nb_d2 = e_nb_d2;
    return v;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // value a reader sees right now, straight from the architectural rules
  function automatic logic [DW-1:0] m_data(input logic [AW-1:0] a, input bit byp);
    if (a == 0) return '0;
    if (byp && reg_write && write_register == a) return write_data;
    return m_mem[a];
  endfunction

  function automatic logic m_busy(input logic [AW-1:0] a, input bit byp);
    if (a == 0) return 1'b0;
    if (byp && reg_write && write_register == a) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_mem[i] = '0;
      m_pend[i] = 1'b0;
    end
    lat_d1 = '0; lat_d2 = '0; lat_b1 = 1'b0; lat_b2 = 1'b0;
  endtask

  task automatic drive(input logic wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [AW-1:0] r1, input logic [AW-1:0] r2, input logic rs,
                       input logic [AW-1:0] rsa, input logic fl);
    reg_write = wr; write_register = wa; write_data = wd;
    read_register_1 = r1; read_register_2 = r2;
    reserve = rs; reserve_register = rsa; flush = fl;
  endtask

  // called just after a falling edge with inputs applied: compares all three
  // instances to the model, then advances the model across the rising edge
  task automatic cycle_check();
    logic [DW-1:0] n_d1, n_d2;
    logic          n_b1, n_b2;
    #2;
    check("a_data1", if_a.read_data_1, m_data(read_register_1, 1'b1));
    check("a_data2", if_a.read_data_2, m_data(read_register_2, 1'b1));
    check("a_busy1", 32'(if_a.busy_1), 32'(m_busy(read_register_1, 1'b1)));
    check("a_busy2", 32'(if_a.busy_2), 32'(m_busy(read_register_2, 1'b1)));
    check("b_data1", if_b.read_data_1, m_data(read_register_1, 1'b0));
    check("b_data2", if_b.read_data_2, m_data(read_register_2, 1'b0));
    check("b_busy1", 32'(if_b.busy_1), 32'(m_busy(read_register_1, 1'b0)));
    check("b_busy2", 32'(if_b.busy_2), 32'(m_busy(read_register_2, 1'b0)));
    check("c_data1", if_c.read_data_1, lat_d1);
    check("c_data2", if_c.read_data_2, lat_d2);
    check("c_busy1", 32'(if_c.busy_1), 32'(lat_b1));
    check("c_busy2", 32'(if_c.busy_2), 32'(lat_b2));
    n_d1 = m_data(read_register_1, 1'b1);
    n_d2 = m_data(read_register_2, 1'b1);
    n_b1 = m_busy(read_register_1, 1'b1);
    n_b2 = m_busy(read_register_2, 1'b1);
    @(posedge clk);
    if (reg_write && write_register != 0) m_mem[write_register] = write_data;
    if (flush) begin
      for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
    end else begin
      if (reg_write && write_register != 0) m_pend[write_register] = 1'b0;
      if (reserve && reserve_register != 0) m_pend[reserve_register] = 1'b1;
    end
    lat_d1 = n_d1; lat_d2 = n_d2; lat_b1 = n_b1; lat_b2 = n_b2;
    @(negedge clk);
  endtask

  initial begin
    // directed vectors, expectations for the bypass/comb instance plus port-2 data
    // of the non-bypass instance, written out from the architectural rules
    vt[0]  = mk(1, 5, 32'hDEADBEEF, 5, 5, 0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 32'h0);
    vt[1]  = mk(0, 0, 32'h0, 5, 0, 0, 0, 0, 32'hDEADBEEF, 32'h0, 0, 0, 32'h0);
    vt[2]  = mk(1, 0, 32'h1234, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    vt[3]  = mk(0, 0, 32'h0, 0, 5, 0, 0, 0, 32'h0, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF);
    vt[4]  = mk(1, 7, 32'hA5A5A5A5, 5, 7, 0, 0, 0, 32'hDEADBEEF, 32'hA5A5A5A5, 0, 0, 32'h0);
    vt[5]  = mk(0, 0, 32'h0, 10, 10, 1, 10, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    vt[6]  = mk(0, 0, 32'h0, 10, 7, 0, 0, 0, 32'h0, 32'hA5A5A5A5, 1, 0, 32'hA5A5A5A5);
    vt[7]  = mk(1, 10, 32'h55, 10, 10, 0, 0, 0, 32'h55, 32'h55, 0, 0, 32'h0);
    vt[8]  = mk(0, 0, 32'h0, 10, 10, 0, 0, 0, 32'h55, 32'h55, 0, 0, 32'h55);
    vt[9]  = mk(1, 10, 32'h66, 10, 10, 1, 10, 0, 32'h66, 32'h66, 0, 0, 32'h55);
    vt[10] = mk(0, 0, 32'h0, 10, 10, 0, 0, 0, 32'h66, 32'h66, 1, 1, 32'h66);
    vt[11] = mk(0, 0, 32'h0, 3, 4, 1, 3, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    vt[12] = mk(0, 0, 32'h0, 3, 4, 1, 4, 0, 32'h0, 32'h0, 1, 0, 32'h0);
    vt[13] = mk(0, 0, 32'h0, 3, 4, 1, 5, 0, 32'h0, 32'h0, 1, 1, 32'h0);
    vt[14] = mk(0, 0, 32'h0, 5, 6, 1, 6, 1, 32'hDEADBEEF, 32'h0, 1, 0, 32'h0);
    vt[15] = mk(0, 0, 32'h0, 3, 4, 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    vt[16] = mk(0, 0, 32'h0, 5, 6, 0, 0, 0, 32'hDEADBEEF, 32'h0, 0, 0, 32'h0);
    vt[17] = mk(0, 0, 32'h0, 10, 6, 0, 0, 0, 32'h66, 32'h0, 0, 0, 32'h0);
    vt[18] = mk(1, 6, 32'h77, 6, 10, 1, 6, 1, 32'h77, 32'h66, 0, 0, 32'h66);
    vt[19] = mk(0, 0, 32'h0, 6, 6, 0, 0, 0, 32'h77, 32'h77, 0, 0, 32'h77);

    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    check("reset_c_data1", if_c.read_data_1, 32'h0);
    check("reset_a_busy1", 32'(if_a.busy_1), 32'h0);
    reset = 1'b1;

    // every index on both ports reads as idle zero after reset
    for (int i = 0; i < N; i++) begin
      drive(0, 0, 0, 5'(i), 5'(N - 1 - i), 0, 0, 0);
      cycle_check();
    end

    for (int k = 0; k < 20; k++) begin
      drive(vt[k].wr, vt[k].wa, vt[k].wd, vt[k].r1, vt[k].r2, vt[k].rs, vt[k].rsa, vt[k].fl);
      #1;
      check($sformatf("vec%0d_data1", k), if_a.read_data_1, vt[k].e_d1);
      check($sformatf("vec%0d_data2", k), if_a.read_data_2, vt[k].e_d2);
      check($sformatf("vec%0d_busy1", k), 32'(if_a.busy_1), 32'(vt[k].e_b1));
      check($sformatf("vec%0d_busy2", k), 32'(if_a.busy_2), 32'(vt[k].e_b2));
      check($sformatf("vec%0d_nobypass_data2", k), if_b.read_data_2, vt[k].e_nb_d2);
      cycle_check();
    end

    // registered read: address change x5 -> x6 shows up one edge later
    drive(0, 0, 0, 5, 5, 0, 0, 0);
    cycle_check();
    drive(0, 0, 0, 6, 5, 0, 0, 0);
    #1;
    check("lat_holds_x5", if_c.read_data_1, 32'hDEADBEEF);
    cycle_check();
    #1;
    check("lat_shows_x6", if_c.read_data_1, 32'h77);

    // reset mid-run clears registered outputs and storage without waiting for an edge
    reset = 1'b0;
    #1;
    check("midreset_c_data1", if_c.read_data_1, 32'h0);
    check("midreset_c_data2", if_c.read_data_2, 32'h0);
    check("midreset_a_data1", if_a.read_data_1, 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 0, 6, 10, 0, 0, 0);
    cycle_check();

    // randomized traffic, addresses often squeezed into x0..x3 to force collisions
    for (int n = 0; n < 800; n++) begin
      logic          narrow;
      logic [AW-1:0] a0, a1, a2, a3;
      narrow = 1'($urandom_range(0, 1));
      a0 = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, N - 1));
      a1 = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, N - 1));
      a2 = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, N - 1));
      a3 = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, N - 1));
      drive(1'($urandom_range(0, 1)), a0, $urandom(), a1, a2,
            1'($urandom_range(0, 2) == 0), a3, 1'($urandom_range(0, 15) == 0));
      cycle_check();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
